usb_line_editor: RTL and testbench
==================================

# usb_line_editor

Line-editing stage between `usb_cdc` and the Forth core. It consumes the CDC OUT byte stream and assembles bytes into a line buffer. It handles backspace, echoes edits back through the CDC IN stream, and presents each completed line to the core for random-access reading. It also merges the core's own transmit bytes into the CDC IN stream, with echo bytes taking priority.

## Interface
Parameters:
- `LINE_LEN`, 64: maximum stored characters per line (2..255).
- `ECHO`, 1: 1 generates echo bytes; 0 suppresses all echo.

Ports. Counter width `CW = $clog2(LINE_LEN+1)`; address width `AW = $clog2(LINE_LEN)`.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `usb_out_data_i`  in  8  byte from `usb_cdc` `out_data_o`.
- `usb_out_valid_i`  in  1  byte valid.
- `usb_out_ready_o`  out  1  byte consumed when high together with valid.
- `usb_in_data_o`  out  8  byte to `usb_cdc` `in_data_i`.
- `usb_in_valid_o`  out  1  byte valid.
- `usb_in_ready_i`  in  1  byte consumed when high together with valid.
- `cpu_tx_data_i`  in  8  core transmit byte.
- `cpu_tx_valid_i`  in  1  core transmit valid.
- `cpu_tx_ready_o`  out  1  core byte accepted when high together with valid.
- `line_valid_o`  out  1  complete line held in the buffer.
- `line_len_o`  out  CW  character count of the held line (CR excluded).
- `line_rd_addr_i`  in  AW  read address.
- `line_rd_data_o`  out  8  buffer byte, registered.
- `line_done_i`  in  1  single-cycle pulse; releases the line.

## Operation
- States:
  - EDIT: accepting bytes.
  - EOL: CR echo draining.
  - READY: line held.
- Character count register `cnt` (CW bits).
- Echo queue: up to 3 bytes, with count `eq`.
- Output register: `usb_in_data_o` / `usb_in_valid_o`.
- `usb_out_ready_o = (state==EDIT) && (eq==0)`.
- Accepted byte in EDIT, by value:
  - 0x20..0x7E:
    - if `cnt<LINE_LEN`: write buf[cnt], `cnt+1`, echo the byte.
    - otherwise: drop the byte, echo 0x07.
  - 0x08 or 0x7F:
    - if `cnt>0`: `cnt-1`, echo 0x08 0x20 0x08.
    - otherwise: no action, no echo.
  - 0x0D: echo 0x0D 0x0A, go to EOL.
  - 0x0A and all other control codes: dropped, no echo.
- With ECHO=0:
  - The queue never loads.
  - 0x0D goes directly to READY.
- EOL → READY once the last echo byte (0x0A) is accepted on the IN handshake (valid & ready).
- READY:
  - `line_valid_o=1` and `line_len_o=cnt`; the OUT stream is stalled.
  - `line_done_i` → `cnt=0`, state EDIT.
  - `line_done_i` outside READY is ignored.
- Output register:
  - Loads when empty, or in the same cycle its current byte is accepted.
  - Source priority: echo queue head first, then the CPU byte.
  - Once `usb_in_valid_o` is high, data and valid are held until accepted; a pending echo never preempts a loaded CPU byte.
- `cpu_tx_ready_o = (output reg empty or being accepted) && (eq==0)`.
- CPU bytes are forwarded in all states, including READY.
- Read port:
  - `line_rd_data_o` = buf[`line_rd_addr_i`] sampled at the previous clock.
  - Content at addresses ≥ `line_len_o` is unspecified.
- Buffer contents are not cleared by `line_done_i` or by reset.

## Timing
- Reset values:
  - Outputs: `usb_out_ready_o=0`, `usb_in_valid_o=0`, `usb_in_data_o=0`, `cpu_tx_ready_o=0`, `line_valid_o=0`, `line_len_o=0`, `line_rd_data_o=0`.
  - Internal: state EDIT, `cnt=0`, `eq=0`.
- First cycle after reset release: `usb_out_ready_o=1` and `cpu_tx_ready_o=1`.
- Byte accepted in cycle N:
  - The echo queue loads in N+1.
  - The first echo byte is on `usb_in_valid_o` in N+2, provided the output register is free.
  - `usb_out_ready_o` stays low from N+1 until the last echo byte has been loaded into the output register.
- Echo throughput: 1 byte/cycle with `usb_in_ready_i` held high.
- `line_valid_o` rises the cycle after the 0x0A is accepted; with ECHO=0, the cycle after the 0x0D is accepted.
- `line_done_i` in cycle M:
  - `line_valid_o=0` and `line_len_o=0` in M+1.
  - `usb_out_ready_o=1` in M+1.
- Read latency: 1 cycle.
- Reset asserted mid-line or mid-echo: all outputs return to reset values immediately; queued echo bytes are lost.

## Test plan
- Send "AB",0x0D with ready held high → IN stream 0x41 0x42 0x0D 0x0A; `line_valid_o=1`, `line_len_o=2`; reads at addr 0,1 give 0x41, 0x42 one cycle after the address is applied.
- Send "AB",0x08,"C",0x0D → echo 41 42 08 20 08 43 0D 0A; line = "AC", len 2. Send 0x7F on an empty line → no echo, `cnt` stays 0.
- LINE_LEN=4: send "ABCDE",0x0D → fifth byte echoes 0x07, `line_len_o=4`. Pulse `line_done_i` → `line_valid_o` low next cycle, next "X",0x0D gives len 1.
- CPU streams 0x55 continuously while the host types "Z" → no byte lost or reordered; each loaded 0x55 is held until accepted; 0x5A appears between CPU bytes; `cpu_tx_ready_o` is low while `eq≠0`.
- `usb_in_ready_i` held low for 20 cycles during echo → output data and valid stay stable, `usb_out_ready_o` stays low, no OUT byte is consumed.
- ECHO=0, 0x0A and 0x01 mixed into the input, then reset asserted mid-line → no IN traffic; 0x0A and 0x01 are not stored; after reset, `line_len_o=0` and `usb_out_ready_o=1` on the first cycle after release.

Source files
------------

// File: rtl/usb_line_editor.sv
// usb_line_editor
// Line-editing stage between the CDC byte streams and the Forth core.
// Bytes arriving on the OUT stream are assembled into a line buffer with
// backspace handling; edits are echoed back on the IN stream. A completed
// line (terminated by CR) is held for random-access reading until the core
// releases it. Core transmit bytes share the IN stream, with echo bytes
// taking priority whenever the output register is free to load.
//
// Ports:
//   clk_i, rstn_i                      clock, async active-low reset
//   usb_out_data/valid_i, _ready_o     byte stream from the host
//   usb_in_data/valid_o, _ready_i      byte stream to the host
//   cpu_tx_data/valid_i, _ready_o      core transmit bytes
//   line_valid_o, line_len_o           held line status and length
//   line_rd_addr_i, line_rd_data_o     registered read port into the buffer
//   line_done_i                        pulse releasing the held line
module usb_line_editor #(
    parameter int LINE_LEN = 64,
    parameter int ECHO     = 1,
    localparam int CW = $clog2(LINE_LEN + 1),
    localparam int AW = $clog2(LINE_LEN)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [7:0]    usb_out_data_i,
    input  logic          usb_out_valid_i,
    output logic          usb_out_ready_o,
    output logic [7:0]    usb_in_data_o,
    output logic          usb_in_valid_o,
    input  logic          usb_in_ready_i,
    input  logic [7:0]    cpu_tx_data_i,
    input  logic          cpu_tx_valid_i,
    output logic          cpu_tx_ready_o,
    output logic          line_valid_o,
    output logic [CW-1:0] line_len_o,
    input  logic [AW-1:0] line_rd_addr_i,
    output logic [7:0]    line_rd_data_o,
    input  logic          line_done_i
);

    typedef enum logic [1:0] {
        ST_EDIT  = 2'd0,
        ST_EOL   = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    eq_r, eq_s;
    logic [7:0]    q0_r, q1_r, q2_r, q0_s, q1_s, q2_s;
    logic [7:0]    out_data_r, out_data_s;
    logic          out_valid_r, out_valid_s;
    logic          out_echo_r, out_echo_s;
    logic          alive_r;
    logic [7:0]    rd_data_r;
    logic          wr_en_s;
    logic [7:0]    wr_data_s;
    logic          out_ready_s, cpu_ready_s, in_accept_s, load_slot_s;
    logic          printable_s, backspace_s, cr_s;

    logic [7:0]    line_mem [2**AW];

    // alive_r keeps the combinational ready outputs low while reset is held
    assign out_ready_s = alive_r && (state_r == ST_EDIT) && (eq_r == 2'd0);
    assign in_accept_s = out_valid_r && usb_in_ready_i;
    assign load_slot_s = !out_valid_r || usb_in_ready_i;
    assign cpu_ready_s = alive_r && load_slot_s && (eq_r == 2'd0);

    assign printable_s = (usb_out_data_i >= 8'h20) && (usb_out_data_i <= 8'h7E);
    assign backspace_s = (usb_out_data_i == 8'h08) || (usb_out_data_i == 8'h7F);
    assign cr_s        = (usb_out_data_i == 8'h0D);

    assign usb_out_ready_o = out_ready_s;
    assign cpu_tx_ready_o  = cpu_ready_s;
    assign usb_in_data_o   = out_data_r;
    assign usb_in_valid_o  = out_valid_r;
    assign line_valid_o    = (state_r == ST_READY);
    assign line_len_o      = (state_r == ST_READY) ? cnt_r : {CW{1'b0}};
    assign line_rd_data_o  = rd_data_r;

    // Next-state: output register loading, echo queue push/pop, line FSM
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        eq_s        = eq_r;
        q0_s        = q0_r;
        q1_s        = q1_r;
        q2_s        = q2_r;
        out_data_s  = out_data_r;
        out_valid_s = out_valid_r;
        out_echo_s  = out_echo_r;
        wr_en_s     = 1'b0;
        wr_data_s   = usb_out_data_i;

        // Output register: echo head first, then the core byte; a loaded
        // byte is only replaced in the cycle it is accepted.
        if (load_slot_s) begin
            if (eq_r != 2'd0) begin
                out_data_s  = q0_r;
                out_valid_s = 1'b1;
                out_echo_s  = 1'b1;
                q0_s        = q1_r;
                q1_s        = q2_r;
                q2_s        = 8'h00;
                eq_s        = eq_r - 2'd1;
            end else if (cpu_tx_valid_i && cpu_ready_s) begin
                out_data_s  = cpu_tx_data_i;
                out_valid_s = 1'b1;
                out_echo_s  = 1'b0;
            end else begin
                out_valid_s = 1'b0;
                out_echo_s  = 1'b0;
            end
        end else begin
            out_valid_s = out_valid_r;
        end

        // Pushes only happen with an empty queue (out_ready_s), so they never
        // collide with the pop above.
        case (state_r)
            ST_EDIT: begin
                if (usb_out_valid_i && out_ready_s) begin
                    if (printable_s) begin
                        if (cnt_r < CW'(LINE_LEN)) begin
                            wr_en_s = 1'b1;
                            cnt_s   = cnt_r + CW'(1);
                            if (ECHO != 0) begin
                                q0_s = usb_out_data_i;
                                eq_s = 2'd1;
                            end else begin
                                eq_s = eq_r;
                            end
                        end else if (ECHO != 0) begin
                            q0_s = 8'h07;
                            eq_s = 2'd1;
                        end else begin
                            eq_s = eq_r;
                        end
                    end else if (backspace_s) begin
                        if (cnt_r != {CW{1'b0}}) begin
                            cnt_s = cnt_r - CW'(1);
                            if (ECHO != 0) begin
                                q0_s = 8'h08;
                                q1_s = 8'h20;
                                q2_s = 8'h08;
                                eq_s = 2'd3;
                            end else begin
                                eq_s = eq_r;
                            end
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end else if (cr_s) begin
                        if (ECHO != 0) begin
                            q0_s    = 8'h0D;
                            q1_s    = 8'h0A;
                            eq_s    = 2'd2;
                            state_s = ST_EOL;
                        end else begin
                            state_s = ST_READY;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_EOL: begin
                // The only echo byte in the output register with an empty
                // queue during EOL is the trailing LF.
                if (in_accept_s && out_echo_r && (eq_r == 2'd0)) begin
                    state_s = ST_READY;
                end else begin
                    state_s = state_r;
                end
            end
            ST_READY: begin
                if (line_done_i) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_EDIT;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_EDIT;
            end
        endcase
    end

    // State, counters, echo queue, output register and read-data register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r     <= ST_EDIT;
            cnt_r       <= {CW{1'b0}};
            eq_r        <= 2'd0;
            q0_r        <= 8'h00;
            q1_r        <= 8'h00;
            q2_r        <= 8'h00;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            out_echo_r  <= 1'b0;
            alive_r     <= 1'b0;
            rd_data_r   <= 8'h00;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            eq_r        <= eq_s;
            q0_r        <= q0_s;
            q1_r        <= q1_s;
            q2_r        <= q2_s;
            out_data_r  <= out_data_s;
            out_valid_r <= out_valid_s;
            out_echo_r  <= out_echo_s;
            alive_r     <= 1'b1;
            rd_data_r   <= line_mem[line_rd_addr_i];
        end
    end

    // Line buffer storage; contents intentionally survive reset and release
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            line_mem[cnt_r[AW-1:0]] <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_usb_line_editor.sv
// Directed bench for usb_line_editor: three instances share the input
// stimulus (default, LINE_LEN=4, ECHO=0) and each scenario task checks the
// instance it targets against hand-computed byte sequences.
module tb_usb_line_editor;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] out_data;
    logic       out_valid;
    logic       in_ready;
    logic [7:0] cpu_data;
    logic       cpu_valid;
    logic       line_done;
    logic [5:0] rd_addr;

    logic       a_out_ready, a_in_valid, a_cpu_ready, a_line_valid;
    logic [7:0] a_in_data, a_rd_data;
    logic [6:0] a_line_len;
    logic       b_out_ready, b_in_valid, b_cpu_ready, b_line_valid;
    logic [7:0] b_in_data, b_rd_data;
    logic [2:0] b_line_len;
    logic       c_out_ready, c_in_valid, c_cpu_ready, c_line_valid;
    logic [7:0] c_in_data, c_rd_data;
    logic [6:0] c_line_len;

    int total = 0;
    int bad   = 0;

    bq_t  qa, qb, qc;
    int   cpu_acc  = 0;
    int   hold_bad = 0;
    int   rdy_bad  = 0;
    logic watch_rdy = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    usb_line_editor #(.LINE_LEN(64), .ECHO(1)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .usb_out_data_i(out_data), .usb_out_valid_i(out_valid), .usb_out_ready_o(a_out_ready),
        .usb_in_data_o(a_in_data), .usb_in_valid_o(a_in_valid), .usb_in_ready_i(in_ready),
        .cpu_tx_data_i(cpu_data), .cpu_tx_valid_i(cpu_valid), .cpu_tx_ready_o(a_cpu_ready),
        .line_valid_o(a_line_valid), .line_len_o(a_line_len),
        .line_rd_addr_i(rd_addr), .line_rd_data_o(a_rd_data), .line_done_i(line_done)
    );

    usb_line_editor #(.LINE_LEN(4), .ECHO(1)) dut4 (
        .clk_i(clk), .rstn_i(rstn),
        .usb_out_data_i(out_data), .usb_out_valid_i(out_valid), .usb_out_ready_o(b_out_ready),
        .usb_in_data_o(b_in_data), .usb_in_valid_o(b_in_valid), .usb_in_ready_i(in_ready),
        .cpu_tx_data_i(cpu_data), .cpu_tx_valid_i(cpu_valid), .cpu_tx_ready_o(b_cpu_ready),
        .line_valid_o(b_line_valid), .line_len_o(b_line_len),
        .line_rd_addr_i(rd_addr[1:0]), .line_rd_data_o(b_rd_data), .line_done_i(line_done)
    );

    usb_line_editor #(.LINE_LEN(64), .ECHO(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn),
        .usb_out_data_i(out_data), .usb_out_valid_i(out_valid), .usb_out_ready_o(c_out_ready),
        .usb_in_data_o(c_in_data), .usb_in_valid_o(c_in_valid), .usb_in_ready_i(in_ready),
        .cpu_tx_data_i(cpu_data), .cpu_tx_valid_i(cpu_valid), .cpu_tx_ready_o(c_cpu_ready),
        .line_valid_o(c_line_valid), .line_len_o(c_line_len),
        .line_rd_addr_i(rd_addr), .line_rd_data_o(c_rd_data), .line_done_i(line_done)
    );

    // Stream monitor: records IN handshakes, core handshakes and hold/ready rules
    always @(negedge clk) begin
        #2;
        if (rstn) begin
            if (a_in_valid && in_ready) qa.push_back(a_in_data);
            if (b_in_valid && in_ready) qb.push_back(b_in_data);
            if (c_in_valid && in_ready) qc.push_back(c_in_data);
            if (cpu_valid && a_cpu_ready) cpu_acc++;
            if (prev_stall && (a_in_valid !== 1'b1 || a_in_data !== prev_data)) hold_bad++;
            prev_stall = a_in_valid && !in_ready;
            prev_data  = a_in_data;
            if (watch_rdy && !a_out_ready && a_cpu_ready) rdy_bad++;
        end else begin
            qa.delete();
            qb.delete();
            qc.delete();
            cpu_acc    = 0;
            hold_bad   = 0;
            rdy_bad    = 0;
            prev_stall = 1'b0;
        end
    end

    function automatic string q2s(input bq_t q);
        string s = "";
        foreach (q[i]) begin
            if (i != 0) s = {s, " "};
            s = {s, $sformatf("%02x", q[i])};
        end
        return s;
    endfunction

    function automatic logic rdy(input int w);
        case (w)
            0:       return a_out_ready;
            1:       return b_out_ready;
            default: return c_out_ready;
        endcase
    endfunction

    function automatic logic lv(input int w);
        case (w)
            0:       return a_line_valid;
            1:       return b_line_valid;
            default: return c_line_valid;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input int w);
        int n = 0;
        @(negedge clk);
        out_data  = b;
        out_valid = 1'b1;
        #1;
        while (!rdy(w) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_byte: byte %02x not accepted by instance %0d, got ready=0 want 1", b, w);
        end
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    task automatic wait_line(input int w, input string nm);
        int n = 0;
        #1;
        while (!lv(w) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (lv(w) !== 1'b1) begin
            bad++;
            $display("FAIL %s: line_valid got %b want 1", nm, lv(w));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0; out_valid = 1'b0; out_data = 8'h00; cpu_valid = 1'b0;
        cpu_data = 8'h00; line_done = 1'b0; in_ready = 1'b1; rd_addr = 6'd0;
        #1;
        total++;
        if ({a_out_ready, a_in_valid, a_in_data, a_cpu_ready, a_line_valid, a_line_len, a_rd_data} !== 27'd0) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b v=%b d=%02x cpu=%b lv=%b len=%0d rd=%02x want all 0",
                     a_out_ready, a_in_valid, a_in_data, a_cpu_ready, a_line_valid, a_line_len, a_rd_data);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({a_out_ready, a_cpu_ready, c_out_ready, c_line_len, b_line_len} !== {1'b1, 1'b1, 1'b1, 7'd0, 3'd0}) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b cpu=%b rdy0=%b len0=%0d len4=%0d want 1 1 1 0 0",
                     a_out_ready, a_cpu_ready, c_out_ready, c_line_len, b_line_len);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        send_byte(8'h41, 0);
        send_byte(8'h42, 0);
        send_byte(8'h0D, 0);
        wait_line(0, "basic_line");
        total++;
        if (q2s(qa) != "41 42 0d 0a") begin
            bad++;
            $display("FAIL basic_echo: got '%s' want '41 42 0d 0a'", q2s(qa));
        end
        total++;
        if (a_line_len !== 7'd2) begin
            bad++;
            $display("FAIL basic_len: got %0d want 2", a_line_len);
        end
        @(negedge clk); rd_addr = 6'd0;
        @(negedge clk); #1;
        total++;
        if (a_rd_data !== 8'h41) begin
            bad++;
            $display("FAIL basic_rd0: got %02x want 41", a_rd_data);
        end
        rd_addr = 6'd1;
        @(negedge clk); #1;
        total++;
        if (a_rd_data !== 8'h42) begin
            bad++;
            $display("FAIL basic_rd1: got %02x want 42", a_rd_data);
        end
        @(negedge clk); line_done = 1'b1;
        @(negedge clk); line_done = 1'b0;
        #1;
        total++;
        if ({a_line_valid, a_line_len, a_out_ready} !== {1'b0, 7'd0, 1'b1}) begin
            bad++;
            $display("FAIL basic_release: got lv=%b len=%0d rdy=%b want 0 0 1", a_line_valid, a_line_len, a_out_ready);
        end
    endtask

    task automatic test_backspace();
        apply_reset();
        send_byte(8'h41, 0);
        send_byte(8'h42, 0);
        send_byte(8'h08, 0);
        send_byte(8'h43, 0);
        send_byte(8'h0D, 0);
        wait_line(0, "bs_line");
        total++;
        if (q2s(qa) != "41 42 08 20 08 43 0d 0a") begin
            bad++;
            $display("FAIL bs_echo: got '%s' want '41 42 08 20 08 43 0d 0a'", q2s(qa));
        end
        total++;
        if (a_line_len !== 7'd2) begin
            bad++;
            $display("FAIL bs_len: got %0d want 2", a_line_len);
        end
        @(negedge clk); rd_addr = 6'd1;
        @(negedge clk); #1;
        total++;
        if (a_rd_data !== 8'h43) begin
            bad++;
            $display("FAIL bs_rd1: got %02x want 43", a_rd_data);
        end
        @(negedge clk); line_done = 1'b1;
        @(negedge clk); line_done = 1'b0;
        send_byte(8'h7F, 0);
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (qa.size() != 8) begin
            bad++;
            $display("FAIL bs_empty_del: got %0d echo bytes want 8 (no echo for DEL on empty line)", qa.size());
        end
        send_byte(8'h0D, 0);
        wait_line(0, "bs_empty_line");
        total++;
        if ({a_line_len, q2s(qa) == "41 42 08 20 08 43 0d 0a 0d 0a"} !== {7'd0, 1'b1}) begin
            bad++;
            $display("FAIL bs_empty_cnt: got len=%0d echo '%s' want len 0 and trailing '0d 0a'", a_line_len, q2s(qa));
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i), 1);
        send_byte(8'h0D, 1);
        wait_line(1, "ovf_line");
        total++;
        if (q2s(qb) != "41 42 43 44 07 0d 0a") begin
            bad++;
            $display("FAIL ovf_echo: got '%s' want '41 42 43 44 07 0d 0a'", q2s(qb));
        end
        total++;
        if (b_line_len !== 3'd4) begin
            bad++;
            $display("FAIL ovf_len: got %0d want 4", b_line_len);
        end
        @(negedge clk); line_done = 1'b1;
        @(negedge clk); line_done = 1'b0;
        #1;
        total++;
        if ({b_line_valid, b_line_len, b_out_ready} !== {1'b0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL ovf_release: got lv=%b len=%0d rdy=%b want 0 0 1", b_line_valid, b_line_len, b_out_ready);
        end
        send_byte(8'h58, 1);
        send_byte(8'h0D, 1);
        wait_line(1, "ovf_next_line");
        total++;
        if (b_line_len !== 3'd1) begin
            bad++;
            $display("FAIL ovf_next_len: got %0d want 1", b_line_len);
        end
        @(negedge clk); rd_addr = 6'd0;
        @(negedge clk); #1;
        total++;
        if (b_rd_data !== 8'h58) begin
            bad++;
            $display("FAIL ovf_rd0: got %02x want 58", b_rd_data);
        end
        rd_addr = 6'd3;
        @(negedge clk); #1;
        total++;
        if (b_rd_data !== 8'h44) begin
            bad++;
            $display("FAIL ovf_rd3: got %02x want 44", b_rd_data);
        end
    endtask

    task automatic test_cpu_merge();
        int n5a = 0;
        int n55 = 0;
        int pos = -1;
        apply_reset();
        cpu_data  = 8'h55;
        cpu_valid = 1'b1;
        watch_rdy = 1'b1;
        fork
            begin
                repeat (3) @(negedge clk);
                send_byte(8'h5A, 0);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    in_ready = ((i % 3) != 2);
                end
            end
        join
        @(negedge clk);
        cpu_valid = 1'b0;
        in_ready  = 1'b1;
        repeat (5) @(negedge clk);
        watch_rdy = 1'b0;
        foreach (qa[i]) begin
            if (qa[i] == 8'h5A) begin n5a++; pos = i; end
            else if (qa[i] == 8'h55) n55++;
        end
        total++;
        if (n5a != 1 || n55 != cpu_acc || qa.size() != cpu_acc + 1) begin
            bad++;
            $display("FAIL merge_count: got 5a=%0d 55=%0d size=%0d want 5a=1 55=%0d size=%0d",
                     n5a, n55, qa.size(), cpu_acc, cpu_acc + 1);
        end
        total++;
        if (pos < 1 || pos > qa.size() - 2 || cpu_acc < 15) begin
            bad++;
            $display("FAIL merge_order: got 5a at %0d of %0d (cpu bytes %0d) want between cpu bytes", pos, qa.size(), cpu_acc);
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL merge_hold: got %0d changes while stalled want 0", hold_bad);
        end
        total++;
        if (rdy_bad != 0) begin
            bad++;
            $display("FAIL merge_cpu_ready: got %0d cycles with cpu ready during echo want 0", rdy_bad);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        apply_reset();
        send_byte(8'h51, 0);
        repeat (4) @(negedge clk);
        in_ready = 1'b0;
        send_byte(8'h08, 0);
        #1;
        while (!a_in_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            out_data  = 8'h52;
            out_valid = 1'b1;
            #1;
            total++;
            if ({a_in_valid, a_in_data, a_out_ready} !== {1'b1, 8'h08, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%02x rdy=%b want 1 08 0", i, a_in_valid, a_in_data, a_out_ready);
            end
        end
        @(negedge clk);
        out_valid = 1'b0;
        in_ready  = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (q2s(qa) != "51 08 20 08") begin
            bad++;
            $display("FAIL stall_echo: got '%s' want '51 08 20 08'", q2s(qa));
        end
        send_byte(8'h53, 0);
        repeat (4) @(negedge clk);
        in_ready = 1'b0;
        send_byte(8'h08, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if ({a_in_valid, a_in_data, a_out_ready, a_cpu_ready} !== 11'd0) begin
            bad++;
            $display("FAIL stall_reset: got v=%b d=%02x rdy=%b cpu=%b want 0 00 0 0", a_in_valid, a_in_data, a_out_ready, a_cpu_ready);
        end
        apply_reset();
        repeat (6) @(negedge clk);
        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL stall_lost_echo: got '%s' want no bytes after reset", q2s(qa));
        end
    endtask

    task automatic test_noecho();
        apply_reset();
        send_byte(8'h48, 2);
        send_byte(8'h0A, 2);
        send_byte(8'h49, 2);
        send_byte(8'h01, 2);
        send_byte(8'h0D, 2);
        #1;
        total++;
        if ({c_line_valid, c_line_len} !== {1'b1, 7'd2}) begin
            bad++;
            $display("FAIL noecho_line: got lv=%b len=%0d want 1 2 (cycle after CR)", c_line_valid, c_line_len);
        end
        @(negedge clk); rd_addr = 6'd0;
        @(negedge clk); #1;
        total++;
        if (c_rd_data !== 8'h48) begin
            bad++;
            $display("FAIL noecho_rd0: got %02x want 48", c_rd_data);
        end
        rd_addr = 6'd1;
        @(negedge clk); #1;
        total++;
        if (c_rd_data !== 8'h49) begin
            bad++;
            $display("FAIL noecho_rd1: got %02x want 49", c_rd_data);
        end
        @(negedge clk); line_done = 1'b1;
        @(negedge clk); line_done = 1'b0;
        send_byte(8'h4A, 2);
        send_byte(8'h0A, 2);
        total++;
        if (qc.size() != 0) begin
            bad++;
            $display("FAIL noecho_traffic: got '%s' want no IN bytes", q2s(qc));
        end
        apply_reset();
        total++;
        if ({c_line_valid, c_line_len, c_in_valid} !== {1'b0, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL noecho_after_reset: got lv=%b len=%0d v=%b want 0 0 0", c_line_valid, c_line_len, c_in_valid);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        out_data  = 8'h00;
        out_valid = 1'b0;
        in_ready  = 1'b1;
        cpu_data  = 8'h00;
        cpu_valid = 1'b0;
        line_done = 1'b0;
        rd_addr   = 6'd0;
        test_reset();
        test_basic();
        test_backspace();
        test_overflow();
        test_cpu_merge();
        test_stall();
        test_noecho();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "time limit");
    end

endmodule
